// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: states, opcodes,
// immediate-format selects (also used by the sign-extension unit) and ALU ops.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_LOAD_WB  = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_HALT     = 4'd10
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [1:0] IMM_NONE = 2'd0;
  localparam logic [1:0] IMM_I    = 2'd1;
  localparam logic [1:0] IMM_S    = 2'd2;
  localparam logic [1:0] IMM_B    = 2'd3;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for the memory handshake: synchronous clear, count
// enable, and an expiry flag raised on the LIMIT-th consecutive wait cycle.
module mem_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // LIMIT == 0 disables the timeout entirely.
  assign expired = (LIMIT != 0) && en && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback.
// Optional performance counters are built when PERF_CNT_EN is defined.
// Memory handshake: mem_req/mem_we are held from request start through the
// cycle where mem_ready is high; the transfer completes on that edge.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int OPCODE_W    = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic [1:0]  imm_sel,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        rf_we,
  output logic        result_src,
  output logic        illegal,
  output logic        bus_err,
  output logic        busy,
`ifdef PERF_CNT_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt,
`endif
  output logic [3:0]  dbg_state
);

  state_t state, state_nx;
  logic   is_store, is_store_nx;
  logic   illegal_nx, bus_err_nx;
  logic   wait_en, wait_clr, wait_exp;

  logic [OPCODE_W-1:0] opcode;
  logic [2:0]          funct3;
  logic                unused_instr;

  assign opcode       = instr[OPCODE_W-1:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31:15], instr[11:OPCODE_W]};
  assign dbg_state    = state;

  assign wait_en  = is_mem_state(state) && !mem_ready;
  assign wait_clr = !is_mem_state(state) || mem_ready;

  mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wait_clr),
    .en      (wait_en),
    .expired (wait_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      is_store <= 1'b0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      is_store <= is_store_nx;
      illegal  <= illegal_nx;
      bus_err  <= bus_err_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    is_store_nx = is_store;
    illegal_nx  = illegal;
    bus_err_nx  = bus_err;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 1'b0;
    imm_sel     = IMM_NONE;
    alu_src_b   = 1'b0;
    alu_op      = ALU_ADD;
    rf_we       = 1'b0;
    result_src  = 1'b0;
    busy        = 1'b1;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we    = 1'b1;
          pc_we    = 1'b1;
          state_nx = S_DECODE;
        end else if (wait_exp) begin
          bus_err_nx = 1'b1;
          state_nx   = S_HALT;
        end
      end
      S_DECODE: begin
        is_store_nx = (opcode == OP_STORE);
        case (opcode)
          OP_R:              state_nx = S_EXEC_R;
          OP_I:              state_nx = S_EXEC_I;
          OP_LOAD, OP_STORE: state_nx = S_MEM_ADDR;
          // Only BEQ is implemented; funct3 is checked here while instr is valid.
          OP_BRANCH: begin
            if (funct3 == F3_BEQ) begin
              state_nx = S_BRANCH;
            end else begin
              illegal_nx = 1'b1;
              state_nx   = S_HALT;
            end
          end
          default: begin
            illegal_nx = 1'b1;
            state_nx   = S_HALT;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_op   = ALU_FUNCT;
        state_nx = S_ALU_WB;
      end
      S_EXEC_I: begin
        imm_sel   = IMM_I;
        alu_src_b = 1'b1;
        alu_op    = ALU_FUNCT;
        state_nx  = S_ALU_WB;
      end
      S_ALU_WB: begin
        rf_we    = 1'b1;
        state_nx = S_FETCH;
      end
      S_MEM_ADDR: begin
        imm_sel   = is_store ? IMM_S : IMM_I;
        alu_src_b = 1'b1;
        state_nx  = is_store ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        imm_sel = IMM_I;
        if (mem_ready) begin
          state_nx = S_LOAD_WB;
        end else if (wait_exp) begin
          bus_err_nx = 1'b1;
          state_nx   = S_HALT;
        end
      end
      S_LOAD_WB: begin
        rf_we      = 1'b1;
        result_src = 1'b1;
        state_nx   = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        imm_sel = IMM_S;
        if (mem_ready) begin
          state_nx = S_FETCH;
        end else if (wait_exp) begin
          bus_err_nx = 1'b1;
          state_nx   = S_HALT;
        end
      end
      S_BRANCH: begin
        imm_sel  = IMM_B;
        alu_op   = ALU_SUB;
        pc_we    = zero;
        pc_src   = zero;
        state_nx = S_FETCH;
      end
      S_HALT: begin
        busy = 1'b0;
      end
      default: state_nx = S_HALT;
    endcase

    // Held in reset: every strobe drops immediately, without waiting for a clock.
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 1'b0;
      imm_sel    = IMM_NONE;
      alu_src_b  = 1'b0;
      alu_op     = ALU_ADD;
      rf_we      = 1'b0;
      result_src = 1'b0;
      busy       = 1'b0;
    end
  end

`ifdef PERF_CNT_EN
  logic retire;
  assign retire = (state_nx == S_FETCH) &&
                  ((state == S_ALU_WB) || (state == S_LOAD_WB) ||
                   (state == S_MEM_WR) || (state == S_BRANCH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (busy)   cycle_cnt   <= cycle_cnt + 32'd1;
      if (retire) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: expected per-cycle control words are
// queued as each step is driven and popped when the outputs are sampled.
module tb_multicycle_ctrl;

  localparam int W = 15;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, ir_we, pc_we, pc_src;
  logic [1:0]  imm_sel;
  logic        alu_src_b;
  logic [1:0]  alu_op;
  logic        rf_we, result_src, illegal, bus_err, busy;
  logic [3:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(16), .OPCODE_W(7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .imm_sel    (imm_sel),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .rf_we      (rf_we),
    .result_src (result_src),
    .illegal    (illegal),
    .bus_err    (bus_err),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: {req,we,ir_we,pc_we,pc_src,imm[1:0],asb,aop[1:0],rf_we,rsrc,ill,berr,busy}
  function automatic logic [W-1:0] cw(input logic req, we, irw, pcw, pcs,
                                      input logic [1:0] imm, input logic asb,
                                      input logic [1:0] aop, input logic rfw, rs,
                                      ill, be, bsy);
    return {req, we, irw, pcw, pcs, imm, asb, aop, rfw, rs, ill, be, bsy};
  endfunction

  function automatic logic [W-1:0] observed();
    return {mem_req, mem_we, ir_we, pc_we, pc_src, imm_sel, alu_src_b, alu_op,
            rf_we, result_src, illegal, bus_err, busy};
  endfunction

  // Scoreboard: pop the oldest expectation and compare against the outputs.
  task automatic check_now(input logic [W-1:0] e, input string tag);
    logic [W-1:0] want;
    logic [W-1:0] got;
    exp_q.push_back(e);
    #1;
    got  = observed();
    want = exp_q.pop_front();
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, want);
    end
  endtask

  // Driver: called at a falling edge; drives inputs, checks, then waits one cycle.
  task automatic cyc(input logic rdy, input logic z, input logic [W-1:0] e,
                     input string tag);
    mem_ready = rdy;
    zero      = z;
    check_now(e, tag);
    @(negedge clk);
  endtask

  logic [W-1:0] w_go, w_wait, w_dec, w_zero;

  initial begin
    w_go   = cw(1,0,1,1,0, 2'd0,0,2'd0, 0,0,0,0,1);
    w_wait = cw(1,0,0,0,0, 2'd0,0,2'd0, 0,0,0,0,1);
    w_dec  = cw(0,0,0,0,0, 2'd0,0,2'd0, 0,0,0,0,1);
    w_zero = '0;

    rst_n = 1'b0; instr = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_now(w_zero, "reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // ADDI x1,x0,5 ; mem_ready high in DECODE must be ignored
    instr = 32'h00500093;
    cyc(1, 0, w_go, "addi_fetch");
    cyc(1, 0, w_dec, "addi_decode");
    cyc(0, 0, cw(0,0,0,0,0, 2'd1,1,2'd2, 0,0,0,0,1), "addi_exec_i");
    cyc(0, 0, cw(0,0,0,0,0, 2'd0,0,2'd0, 1,0,0,0,1), "addi_alu_wb");

    // LW with 3 wait states
    instr = 32'h0000A103;
    cyc(1, 0, w_go, "lw_fetch");
    cyc(0, 0, w_dec, "lw_decode");
    cyc(0, 0, cw(0,0,0,0,0, 2'd1,1,2'd0, 0,0,0,0,1), "lw_mem_addr");
    for (int i = 0; i < 3; i++)
      cyc(0, 0, cw(1,0,0,0,0, 2'd1,0,2'd0, 0,0,0,0,1), "lw_rd_wait");
    cyc(1, 0, cw(1,0,0,0,0, 2'd1,0,2'd0, 0,0,0,0,1), "lw_rd_done");
    cyc(0, 0, cw(0,0,0,0,0, 2'd0,0,2'd0, 1,1,0,0,1), "lw_load_wb");

    // SW with a random number of wait states
    instr = 32'h0020A023;
    cyc(1, 0, w_go, "sw_fetch");
    cyc(0, 0, w_dec, "sw_decode");
    cyc(0, 0, cw(0,0,0,0,0, 2'd2,1,2'd0, 0,0,0,0,1), "sw_mem_addr");
    repeat ($urandom_range(0, 4))
      cyc(0, 0, cw(1,1,0,0,0, 2'd2,0,2'd0, 0,0,0,0,1), "sw_wr_wait");
    cyc(1, 0, cw(1,1,0,0,0, 2'd2,0,2'd0, 0,0,0,0,1), "sw_wr_done");

    // ADD (R-type), zero high outside BRANCH must be ignored
    instr = 32'h002081B3;
    cyc(1, 1, w_go, "add_fetch");
    cyc(0, 1, w_dec, "add_decode");
    cyc(0, 1, cw(0,0,0,0,0, 2'd0,0,2'd2, 0,0,0,0,1), "add_exec_r");
    cyc(0, 0, cw(0,0,0,0,0, 2'd0,0,2'd0, 1,0,0,0,1), "add_alu_wb");

    // BEQ taken / not taken
    instr = 32'h00000463;
    cyc(1, 0, w_go, "beq1_fetch");
    cyc(0, 0, w_dec, "beq1_decode");
    cyc(0, 1, cw(0,0,0,1,1, 2'd3,0,2'd1, 0,0,0,0,1), "beq_taken");
    cyc(1, 0, w_go, "beq0_fetch");
    cyc(0, 0, w_dec, "beq0_decode");
    cyc(0, 0, cw(0,0,0,0,0, 2'd3,0,2'd1, 0,0,0,0,1), "beq_not_taken");

    // mem_ready on the 16th fetch cycle completes normally
    instr = 32'h00500093;
    for (int i = 0; i < 15; i++) cyc(0, 0, w_wait, "late_fetch_wait");
    cyc(1, 0, w_go, "late_fetch_ready");
    cyc(0, 0, w_dec, "late_decode_no_err");
    cyc(0, 0, cw(0,0,0,0,0, 2'd1,1,2'd2, 0,0,0,0,1), "late_exec_i");
    cyc(0, 0, cw(0,0,0,0,0, 2'd0,0,2'd0, 1,0,0,0,1), "late_alu_wb");

    // Reset asserted while MEM_RD is waiting
    instr = 32'h0000A103;
    cyc(1, 0, w_go, "rstmid_fetch");
    cyc(0, 0, w_dec, "rstmid_decode");
    cyc(0, 0, cw(0,0,0,0,0, 2'd1,1,2'd0, 0,0,0,0,1), "rstmid_addr");
    cyc(0, 0, cw(1,0,0,0,0, 2'd1,0,2'd0, 0,0,0,0,1), "rstmid_rd_wait");
    #2;
    rst_n = 1'b0;
    check_now(w_zero, "rstmid_async_drop");
    @(negedge clk);
    rst_n = 1'b1;

    // 16 fetch cycles without mem_ready -> bus_err and HALT
    for (int i = 0; i < 16; i++) cyc(0, 0, w_wait, "timeout_fetch_wait");
    for (int i = 0; i < 3; i++)
      cyc(1, 0, cw(0,0,0,0,0, 2'd0,0,2'd0, 0,0,0,1,0), "timeout_halt");

    rst_n = 1'b0;
    check_now(w_zero, "halt_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Unsupported opcode 0x7F
    instr = 32'h0000007F;
    cyc(1, 0, w_go, "ill_fetch_clean");
    cyc(1, 0, w_dec, "ill_decode");
    for (int i = 0; i < 3; i++)
      cyc(1, 1, cw(0,0,0,0,0, 2'd0,0,2'd0, 0,0,1,0,0), "ill_halt");

    rst_n = 1'b0;
    check_now(w_zero, "ill_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // BNE (funct3 = 001) is not supported
    instr = 32'h00001463;
    cyc(1, 0, w_go, "bne_fetch_clean");
    cyc(0, 1, w_dec, "bne_decode");
    cyc(0, 1, cw(0,0,0,0,0, 2'd0,0,2'd0, 0,0,1,0,0), "bne_halt");

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I subset core: sequences fetch, decode, execute, memory and writeback over shared PC/IR/ALU/memory datapath.
- Drives immediate-format select for the sign-extension unit, ALU operand/op selects, register-file and memory enables.
- Supports a handshaked memory port with wait states.

Parameters:
- MEM_TIMEOUT, 16, max cycles waiting for mem_ready before raising bus_err (0 = no timeout).
- OPCODE_W, 7, opcode field width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  IR contents; decoded in DECODE only.
- zero  in  1  ALU zero flag, sampled in BRANCH.
- mem_ready  in  1  memory accepted/completed current request.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = store request.
- ir_we  out  1  latch fetched word into IR.
- pc_we  out  1  PC update strobe.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- imm_sel  out  2  0 = none, 1 = I/L, 2 = S, 3 = B.
- alu_src_b  out  1  0 = rs2, 1 = immediate.
- alu_op  out  2  0 = add, 1 = sub (compare), 2 = funct decode.
- rf_we  out  1  register-file write strobe.
- result_src  out  1  0 = ALU result, 1 = load data.
- illegal  out  1  sticky: unsupported opcode decoded.
- bus_err  out  1  sticky: memory timeout.
- busy  out  1  high in every state except HALT.

Behaviour:
- Reset (async, rst_n low): state = FETCH; all strobes, selects, illegal, bus_err, internal wait counter = 0; busy = 1 after release.
- FETCH:
  - mem_req = 1, mem_we = 0.
  - Stay while mem_ready = 0.
  - On mem_ready: ir_we = 1, pc_we = 1, pc_src = 0 for that cycle; go to DECODE.
- DECODE (1 cycle): opcode = instr[6:0].
  - 0110011 -> EXEC_R.
  - 0010011 -> EXEC_I.
  - 0000011 or 0100011 -> MEM_ADDR.
  - 1100011 -> BRANCH.
  - Anything else -> set illegal, go to HALT.
- imm_sel is combinational from state plus opcode:
  - 1 in EXEC_I, and in MEM_ADDR/MEM_RD for loads.
  - 2 in MEM_ADDR/MEM_WR for stores.
  - 3 in BRANCH.
  - 0 otherwise.
- EXEC_R: alu_src_b = 0, alu_op = 2 -> ALU_WB.
- EXEC_I: alu_src_b = 1, alu_op = 2 -> ALU_WB.
- ALU_WB: rf_we = 1, result_src = 0 -> FETCH.
- MEM_ADDR: alu_src_b = 1, alu_op = 0. Load -> MEM_RD; store -> MEM_WR.
- MEM_RD: mem_req = 1, mem_we = 0. Hold until mem_ready, then -> LOAD_WB.
- LOAD_WB: rf_we = 1, result_src = 1 -> FETCH.
- MEM_WR: mem_req = 1, mem_we = 1. Hold until mem_ready, then -> FETCH. rf_we never asserted.
- BRANCH (1 cycle): alu_op = 1.
  - If zero = 1: pc_we = 1, pc_src = 1.
  - Either way -> FETCH.
  - Only BEQ (funct3 = 000) is supported; other funct3 sets illegal and goes to HALT.
- HALT: all strobes 0, busy = 0. Exit only by reset.
- Request rules:
  - mem_req remains high and mem_we stable from request start until the mem_ready cycle inclusive.
  - mem_req drops the cycle after mem_ready.
  - mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Timeout:
  - The wait counter clears on entry to each memory state and increments each cycle mem_ready = 0.
  - When MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT: bus_err = 1, go to HALT.
  - mem_ready in the same cycle as the count reaching MEM_TIMEOUT wins: normal completion, no error.
- Reset asserted mid-transaction: immediate return to FETCH; mem_req drops asynchronously.
- Strobes are Moore outputs except ir_we/pc_we in FETCH and pc_we in BRANCH, which are qualified by mem_ready/zero.

Optional Feature:
- PERF_CNT_EN, when defined, adds:
  - Output cycle_cnt [31:0]: increments every cycle while busy.
  - Output instret_cnt [31:0]: increments on each exit from ALU_WB, LOAD_WB, MEM_WR and BRANCH to FETCH.
  - Both reset to 0 and wrap modulo 2^32.
- When not defined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package rv_ctrl_pkg holds:
  - State enum.
  - Opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH.
  - imm_sel encodings IMM_NONE/IMM_I/IMM_S/IMM_B.
  - alu_op encodings.
- The sign-extension unit must share the same imm_sel encodings.
- One natural sub-module, mem_wait_timer: wait counter with clear, count enable and expiry flag.

Test Plan:
- ADDI x1,x0,5 (0x00500093), mem_ready immediate -> FETCH, DECODE, EXEC_I (imm_sel = 1), ALU_WB (rf_we = 1); 4 cycles; back in FETCH.
- LW 0x0000A103 with 3 wait cycles on data read -> mem_req held 4 cycles in MEM_RD, then LOAD_WB with result_src = 1 and rf_we = 1.
- SW 0x0020A023 -> imm_sel = 2 in MEM_ADDR/MEM_WR, mem_we = 1, rf_we never 1.
- BEQ 0x00000463:
  - zero = 1 -> pc_we = 1 and pc_src = 1 in BRANCH, imm_sel = 3.
  - zero = 0 -> pc_we = 0.
- Opcode 0x7F, or mem_ready held low for 16 cycles -> illegal (respectively bus_err) = 1, busy = 0, stays halted until rst_n pulse.
- rst_n low mid-MEM_RD -> mem_req = 0 asynchronously; after release, FETCH with all flags cleared.
